rr_bus_arb_ctrl: RTL and testbench
==================================

// Module: rr_bus_arb_ctrl
// PURPOSE
//  Registered round-robin bus arbiter controller around the combinational ppa arbiter.
//  Samples N requests, issues a registered one-hot grant and holds it for the winner's tenure.
//  On release it rotates the one-hot priority pointer so the winner's left neighbour is top priority.
//  Sits between bus masters and the shared bus mux; o_grant drives the mux select directly.
// PARAMETERS
//  N         8          number of requesters (>=2)
//  PRIOR_RST 8'h80      reset value of one-hot priority pointer (must be one-hot, width N)
//  MAX_HOLD  16         tenure limit in cycles (used only with ARB_TIMEOUT_EN, >=1)
// PORTS
//  i_bus_clk   in   1          clock, rising edge
//  i_bus_rst   in   1          reset, asynchronous, active-high
//  i_req       in   N          request per master, level; held for whole tenure
//  i_prior_we  in   1          load priority pointer (honoured in IDLE only)
//  i_prior     in   N          one-hot priority value for load
//  o_grant     out  N          registered one-hot grant
//  o_ag        out  1          any grant (|o_grant), registered
//  o_gnt_id    out  $clog2(N)  binary index of granted master (0 when no grant)
//  o_timeout   out  1          1-cycle pulse: tenure forcibly ended
//  o_cfg_err   out  1          1-cycle pulse: i_prior load rejected
// BEHAVIOUR
//  Reset: o_grant=0, o_ag=0, o_gnt_id=0, o_timeout=0, o_cfg_err=0, pointer=PRIOR_RST, state=IDLE.
//  Async reset clears all outputs immediately, no clock edge needed, incl. mid-tenure.
//  Priority: pointer bit p = highest priority; search p, p+1, ... wrapping at N-1 -> 0.
//  FSM IDLE: if |i_req: o_grant<=ppa(pointer,i_req), ->BUSY; grant visible cycle after sampling.
//  FSM IDLE, i_req==0: outputs stay 0.
//  FSM BUSY: hold o_grant while i_req[o_gnt_id]=1; other requests ignored.
//  BUSY release: when i_req[o_gnt_id]=0 at an edge: o_grant<=0, pointer<=rotl(o_grant,1), ->IDLE.
//  Minimum one dead cycle (o_ag=0) between tenures; gives bus turnaround.
//  Shortest tenure 1 cycle: winner drops request the cycle grant appears.
//  Pointer only changes on release or accepted load; wrap: rotl(bit N-1) = bit 0.
//  Priority load: in IDLE, i_prior_we=1 and i_prior one-hot -> pointer<=i_prior that edge.
//  Rejected load: i_prior zero or multi-hot -> pointer unchanged, o_cfg_err pulses next cycle.
//  Load attempted in BUSY: ignored silently, no error.
//  Load and request at same IDLE edge: arbitration uses OLD pointer; new pointer applies afterwards.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: $clog2(MAX_HOLD+1)-bit tenure counter, cleared on entering BUSY.
//    Counter increments each BUSY cycle; on MAX_HOLD granted cycles with request still high,
//    grant cleared, o_timeout pulses, pointer rotates, ->IDLE (same as release).
//    Release and timeout on same edge: treated as release, no o_timeout.
//  ARB_TIMEOUT_EN undefined: no counter, o_timeout tied 0, tenure unbounded.
// STRUCTURE
//  Package arb_pkg: state enum {IDLE,BUSY}, default N, functions rotl1, onehot2bin, is_onehot.
//  Sub-module: ppa (existing parallel prefix arbiter), one instance:
//    i_prior=pointer, i_req=i_req, o_grant feeds grant register.
//  Everything else (FSM, pointer, counter, checks) lives in this module.
// TESTING
//  1 Reset asserted, no clock -> all outputs 0; after release pointer=8'h80 (N=8).
//  2 i_req=8'h48 held 3 cycles, then bit3 dropped -> o_grant=8'h08, o_gnt_id=3 for 3 cycles,
//    then 0; pointer=8'h10.
//  3 Continue: i_req=8'h41 -> o_grant=8'h40; release -> pointer=8'h80;
//    i_req=8'h81 -> o_grant=8'h80 (wrap).
//  4 ARB_TIMEOUT_EN, MAX_HOLD=4, i_req=8'h01 held -> 4 cycles 8'h01, o_timeout pulse,
//    1 dead cycle, regrant 8'h01.
//  5 IDLE load i_prior=8'h24 -> o_cfg_err pulse, pointer unchanged; load 8'h04 accepted;
//    i_req=8'h13 -> o_grant=8'h10.
//  6 Async reset during tenure (o_grant=8'h10) -> o_grant=0 immediately; pointer=PRIOR_RST.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter controller.
// Vector helpers work on a fixed 32-bit carrier, so any N up to 32 is supported.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_N = 8;
    localparam int VEC_W = 32;

    // Rotate left by one within the low n bits; bit n-1 wraps to bit 0.
    function automatic logic [VEC_W-1:0] rotl1(input logic [VEC_W-1:0] v, input int n);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (i < n) r[(i == n - 1) ? 0 : i + 1] = v[i];
        end
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] onehot2bin(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] b;
        b = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (v[i]) b = b | VEC_W'(i);
        end
        return b;
    endfunction

    function automatic logic is_onehot(input logic [VEC_W-1:0] v);
        return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ppa.sv
// Parallel prefix arbiter: grants the first request found searching upward
// from the one-hot priority bit, wrapping from bit N-1 to bit 0.
module ppa #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_prior,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;

    // Doubling the request vector turns the wrap-around search into one borrow
    // chain: subtracting the priority bit clears every request below the winner.
    assign req_dbl = {i_req, i_req};
    assign gnt_dbl = req_dbl & ~(req_dbl - {{N{1'b0}}, i_prior});
    assign o_grant = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

endmodule

// File: rtl/rr_bus_arb_ctrl.sv
// Registered round-robin bus arbiter with tenure hold and rotating priority pointer.
// Optional tenure limit enabled by defining ARB_TIMEOUT_EN.
import arb_pkg::*;

module rr_bus_arb_ctrl #(
    parameter int           N         = ARB_N,
    parameter logic [N-1:0] PRIOR_RST = N'(1) << (N - 1),
    parameter int           MAX_HOLD  = 16
) (
    input  logic                 i_bus_clk,
    input  logic                 i_bus_rst,
    input  logic [N-1:0]         i_req,
    input  logic                 i_prior_we,
    input  logic [N-1:0]         i_prior,
    output logic [N-1:0]         o_grant,
    output logic                 o_ag,
    output logic [$clog2(N)-1:0] o_gnt_id,
    output logic                 o_timeout,
    output logic                 o_cfg_err
);

    localparam int ID_W = $clog2(N);

    arb_state_t    state_q, state_n;
    logic [N-1:0]  grant_q, grant_n;
    logic [N-1:0]  ptr_q, ptr_n;
    logic [N-1:0]  ppa_grant;
    logic [ID_W-1:0] gnt_id_q;
    logic          ag_q;
    logic          cfg_err_q, cfg_err_n;
    logic          held;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             timeout_q, timeout_n;
`endif

    ppa #(.N(N)) u_ppa (
        .i_prior (ptr_q),
        .i_req   (i_req),
        .o_grant (ppa_grant)
    );

    assign held = i_req[gnt_id_q];

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        ptr_n     = ptr_q;
        cfg_err_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt_q;
        timeout_n = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Arbitration sees the old pointer even when a load lands on the same edge.
                if (|i_req) begin
                    grant_n = ppa_grant;
                    state_n = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
                if (i_prior_we) begin
                    if (is_onehot(VEC_W'(i_prior))) ptr_n = i_prior;
                    else                            cfg_err_n = 1'b1;
                end
            end
            BUSY: begin
                if (!held) begin
                    grant_n = '0;
                    ptr_n   = N'(rotl1(VEC_W'(grant_q), N));
                    state_n = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    grant_n   = '0;
                    ptr_n     = N'(rotl1(VEC_W'(grant_q), N));
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
        if (i_bus_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PRIOR_RST;
            ag_q      <= 1'b0;
            gnt_id_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            ptr_q     <= ptr_n;
            ag_q      <= |grant_n;
            gnt_id_q  <= ID_W'(onehot2bin(VEC_W'(grant_n)));
            cfg_err_q <= cfg_err_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
        if (i_bus_rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_grant   = grant_q;
    assign o_ag      = ag_q;
    assign o_gnt_id  = gnt_id_q;
    assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_rr_bus_arb_ctrl.sv
// Directed bench for rr_bus_arb_ctrl (N=8, MAX_HOLD=4); follows ARB_TIMEOUT_EN if defined.
module tb_rr_bus_arb_ctrl;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = '0;
    logic       prior_we = 1'b0;
    logic [7:0] prior = '0;
    logic [7:0] grant;
    logic       ag;
    logic [2:0] gnt_id;
    logic       timeout;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    rr_bus_arb_ctrl #(.N(8), .PRIOR_RST(8'h80), .MAX_HOLD(4)) dut (
        .i_bus_clk  (clk),
        .i_bus_rst  (rst),
        .i_req      (req),
        .i_prior_we (prior_we),
        .i_prior    (prior),
        .o_grant    (grant),
        .o_ag       (ag),
        .o_gnt_id   (gnt_id),
        .o_timeout  (timeout),
        .o_cfg_err  (cfg_err)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gnt(input string tag, input logic [7:0] g, input logic [2:0] id);
        check({tag, ".grant"}, grant, g);
        check({tag, ".ag"}, ag, |g);
        check({tag, ".id"}, gnt_id, id);
    endtask

    initial begin
        // 1: async reset with the clock stopped
        #2 rst = 1'b1;
        #1;
        check_gnt("rst", 8'h00, 3'd0);
        check("rst.timeout", timeout, 1'b0);
        check("rst.cfg_err", cfg_err, 1'b0);
        #2 rst = 1'b0;
        clk_en = 1'b1;
        check("rst.ptr", dut.ptr_q, 8'h80);
        step();
        check_gnt("idle_noreq", 8'h00, 3'd0);

        // 2: 0x48 from pointer 0x80 wins bit 3, held for 3 cycles
        req = 8'h48;
        for (int i = 0; i < 3; i++) begin
            step();
            check_gnt("t2.hold", 8'h08, 3'd3);
        end
        req = 8'h40;
        step();
        check_gnt("t2.release", 8'h00, 3'd0);
        check("t2.ptr", dut.ptr_q, 8'h10);

        // 3: pointer 0x10 -> bit 6; then wrap to bit 7 and back to bit 0
        req = 8'h41;
        step();
        check_gnt("t3.g40", 8'h40, 3'd6);
        req = 8'h01;
        step();
        check_gnt("t3.rel40", 8'h00, 3'd0);
        check("t3.ptr80", dut.ptr_q, 8'h80);
        req = 8'h81;
        step();
        check_gnt("t3.g80", 8'h80, 3'd7);
        req = 8'h00;
        step();
        check("t3.ptr_wrap", dut.ptr_q, 8'h01);

        // 4: single requester held continuously
        req = 8'h01;
        for (int i = 0; i < 4; i++) begin
            step();
            check_gnt("t4.hold", 8'h01, 3'd0);
            check("t4.no_to", timeout, 1'b0);
        end
        step();
`ifdef ARB_TIMEOUT_EN
        check_gnt("t4.dead", 8'h00, 3'd0);
        check("t4.to_pulse", timeout, 1'b1);
        check("t4.ptr", dut.ptr_q, 8'h02);
        step();
        check_gnt("t4.regrant", 8'h01, 3'd0);
        check("t4.to_clear", timeout, 1'b0);
`else
        check_gnt("t4.unbounded", 8'h01, 3'd0);
        check("t4.to_tied", timeout, 1'b0);
`endif
        req = 8'h00;
        step();
        check_gnt("t4.release", 8'h00, 3'd0);
        check("t4.ptr_end", dut.ptr_q, 8'h02);

        // 5: rejected and accepted priority loads, then arbitration from 0x04
        prior_we = 1'b1;
        prior    = 8'h24;
        step();
        check("t5.cfg_err", cfg_err, 1'b1);
        check("t5.ptr_kept", dut.ptr_q, 8'h02);
        prior = 8'h04;
        step();
        check("t5.cfg_ok", cfg_err, 1'b0);
        check("t5.ptr_load", dut.ptr_q, 8'h04);
        prior_we = 1'b0;
        req = 8'h13;
        step();
        check_gnt("t5.g10", 8'h10, 3'd4);
        prior_we = 1'b1;
        prior    = 8'h03;
        step();
        check("t5.busy_noerr", cfg_err, 1'b0);
        check("t5.busy_ptr", dut.ptr_q, 8'h04);
        check_gnt("t5.busy_hold", 8'h10, 3'd4);
        prior_we = 1'b0;

        // 6: async reset mid-tenure clears outputs at once
        #2 rst = 1'b1;
        #1;
        check_gnt("t6.rst", 8'h00, 3'd0);
        check("t6.ptr", dut.ptr_q, 8'h80);
        #3 rst = 1'b0;
        step();
        check_gnt("t6.after", 8'h01, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
